// File: rtl/mem_perf_tracker_pkg.sv
// ---------------------------------------------------------------------------
// mem_perf_tracker_pkg
//   Shared definitions for the memory-side perf counters.
//   - PERF_CTR_BITS_DEFAULT : default width of every perf counter output
//   - PERF_ERR_UNDERFLOW    : perf_err bit for a response with nothing pending
//   - PERF_ERR_OVERFLOW     : perf_err bit for a read beyond MAX_PENDING
//   - perf_ctr_t            : counter type at the default width
// ---------------------------------------------------------------------------
package mem_perf_tracker_pkg;

  localparam int PERF_CTR_BITS_DEFAULT = 44;

  localparam int PERF_ERR_UNDERFLOW = 0;
  localparam int PERF_ERR_OVERFLOW  = 1;

  typedef logic [PERF_CTR_BITS_DEFAULT-1:0] perf_ctr_t;

endpackage

// File: rtl/perf_ctr_accum.sv
// ---------------------------------------------------------------------------
// perf_ctr_accum
//   Wrapping accumulator used for each perf counter.
//   Ports:
//     clk, rst  : clock, asynchronous active-high reset
//     clear     : restart the count; the same cycle's increment is still added
//     inc       : add inc_val this cycle
//     inc_val   : unsigned increment, zero-extended to W bits
//     count     : registered accumulated value (wraps modulo 2^W)
// ---------------------------------------------------------------------------
module perf_ctr_accum #(
  parameter int W  = 44,
  parameter int IW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          inc,
  input  logic [IW-1:0] inc_val,
  output logic [W-1:0]  count
);

  logic [W-1:0] base;
  logic [W-1:0] addend;

  always_comb begin
    base   = clear ? '0 : count;
    addend = inc ? W'(inc_val) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else begin
      count <= base + addend;
    end
  end

endmodule

// File: rtl/mem_perf_tracker.sv
// ---------------------------------------------------------------------------
// mem_perf_tracker
//   Passive monitor of the memory request/response handshake. Counts accepted
//   reads and writes and accumulates read latency as the per-cycle sum of
//   outstanding reads. Never drives or back-pressures the bus.
//
//   Handshake: a transfer happens in a cycle where valid and ready are both
//   high at the rising clk edge; this block only observes that condition.
//
//   Ports:
//     clk, reset          : clock, asynchronous active-high reset
//     mem_req_valid/ready : request handshake; mem_req_rw 1=write, 0=read
//     mem_rsp_valid/ready : read response handshake
//     perf_clear          : synchronous clear of counters and error flags
//     perf_mem_reads      : accepted read requests
//     perf_mem_writes     : accepted write requests
//     perf_mem_latency    : sum over cycles of outstanding reads
//     pending_reads       : current outstanding read count
//     perf_err            : sticky [0] response underflow, [1] pending overflow
//     peak_pending        : (PERF_MEM_PEAK_PENDING_EN only) max pending_reads
//                           since reset or last perf_clear
//
//   Optional build macro: PERF_MEM_PEAK_PENDING_EN
// ---------------------------------------------------------------------------
module mem_perf_tracker
  import mem_perf_tracker_pkg::*;
#(
  parameter int  PERF_CTR_BITS = PERF_CTR_BITS_DEFAULT,
  parameter int  MAX_PENDING   = 64,
  localparam int PEND_BITS     = $clog2(MAX_PENDING + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_req_valid,
  input  logic                     mem_req_ready,
  input  logic                     mem_req_rw,
  input  logic                     mem_rsp_valid,
  input  logic                     mem_rsp_ready,
  input  logic                     perf_clear,
  output logic [PERF_CTR_BITS-1:0] perf_mem_reads,
  output logic [PERF_CTR_BITS-1:0] perf_mem_writes,
  output logic [PERF_CTR_BITS-1:0] perf_mem_latency,
  output logic [PEND_BITS-1:0]     pending_reads,
  output logic [1:0]               perf_err
`ifdef PERF_MEM_PEAK_PENDING_EN
  ,
  output logic [PEND_BITS-1:0]     peak_pending
`endif
);

  logic rd_fire;
  logic wr_fire;
  logic rsp_fire;
  logic underflow;
  logic overflow;
  logic [1:0] err_next;
  logic [PEND_BITS-1:0] pending_next;

  always_comb begin
    rd_fire   = mem_req_valid & mem_req_ready & ~mem_req_rw;
    wr_fire   = mem_req_valid & mem_req_ready &  mem_req_rw;
    rsp_fire  = mem_rsp_valid & mem_rsp_ready;
    underflow = rsp_fire & ~rd_fire & (pending_reads == '0);
    overflow  = rd_fire & ~rsp_fire & (pending_reads == PEND_BITS'(MAX_PENDING));

    // A read and a response in the same cycle cancel; out-of-range moves
    // are held and flagged instead.
    pending_next = pending_reads;
    if (rd_fire & ~rsp_fire & ~overflow) begin
      pending_next = pending_reads + PEND_BITS'(1);
    end else if (rsp_fire & ~rd_fire & ~underflow) begin
      pending_next = pending_reads - PEND_BITS'(1);
    end

    // Clear first, then OR in this cycle's errors so a new error wins.
    err_next = perf_clear ? 2'b00 : perf_err;
    err_next[PERF_ERR_UNDERFLOW] = err_next[PERF_ERR_UNDERFLOW] | underflow;
    err_next[PERF_ERR_OVERFLOW]  = err_next[PERF_ERR_OVERFLOW]  | overflow;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_reads <= '0;
      perf_err      <= 2'b00;
    end else begin
      pending_reads <= pending_next;
      perf_err      <= err_next;
    end
  end

  perf_ctr_accum #(.W(PERF_CTR_BITS), .IW(1)) u_reads (
    .clk     (clk),
    .rst     (reset),
    .clear   (perf_clear),
    .inc     (rd_fire),
    .inc_val (1'b1),
    .count   (perf_mem_reads)
  );

  perf_ctr_accum #(.W(PERF_CTR_BITS), .IW(1)) u_writes (
    .clk     (clk),
    .rst     (reset),
    .clear   (perf_clear),
    .inc     (wr_fire),
    .inc_val (1'b1),
    .count   (perf_mem_writes)
  );

  // Each outstanding read adds one per cycle, so a read answered k cycles
  // after issue contributes exactly k.
  perf_ctr_accum #(.W(PERF_CTR_BITS), .IW(PEND_BITS)) u_latency (
    .clk     (clk),
    .rst     (reset),
    .clear   (perf_clear),
    .inc     (1'b1),
    .inc_val (pending_reads),
    .count   (perf_mem_latency)
  );

`ifdef PERF_MEM_PEAK_PENDING_EN
  // Tracks the registered pending count, so it lags pending_reads by a cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      peak_pending <= '0;
    end else if (perf_clear) begin
      peak_pending <= pending_reads;
    end else if (pending_reads > peak_pending) begin
      peak_pending <= pending_reads;
    end
  end
`endif

endmodule

// File: tb/tb_mem_perf_tracker.sv
module tb_mem_perf_tracker;
  import mem_perf_tracker_pkg::*;

  localparam int MAX_PENDING = 64;
  localparam int PEND_BITS   = $clog2(MAX_PENDING + 1);

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic mem_req_valid, mem_req_ready, mem_req_rw;
  logic mem_rsp_valid, mem_rsp_ready, perf_clear;
  logic [PERF_CTR_BITS_DEFAULT-1:0] perf_mem_reads, perf_mem_writes, perf_mem_latency;
  logic [PEND_BITS-1:0] pending_reads;
  logic [1:0] perf_err;
`ifdef PERF_MEM_PEAK_PENDING_EN
  logic [PEND_BITS-1:0] peak_pending;
`endif

  mem_perf_tracker #(.PERF_CTR_BITS(PERF_CTR_BITS_DEFAULT), .MAX_PENDING(MAX_PENDING)) dut (
    .clk              (clk),
    .reset            (reset),
    .mem_req_valid    (mem_req_valid),
    .mem_req_ready    (mem_req_ready),
    .mem_req_rw       (mem_req_rw),
    .mem_rsp_valid    (mem_rsp_valid),
    .mem_rsp_ready    (mem_rsp_ready),
    .perf_clear       (perf_clear),
    .perf_mem_reads   (perf_mem_reads),
    .perf_mem_writes  (perf_mem_writes),
    .perf_mem_latency (perf_mem_latency),
    .pending_reads    (pending_reads),
    .perf_err         (perf_err)
`ifdef PERF_MEM_PEAK_PENDING_EN
    ,
    .peak_pending     (peak_pending)
`endif
  );

  // scoreboard counters
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // reference model: counters in the wrapping perf type, pending as an int
  perf_ctr_t m_reads, m_writes, m_lat;
  int        m_pend;
  int        m_peak;
  logic [1:0] m_err;

  task automatic model_zero();
    m_reads = '0; m_writes = '0; m_lat = '0;
    m_pend = 0; m_peak = 0; m_err = 2'b00;
  endtask

  task automatic model_tick(input bit rv, rr, rw, sv, sr, clr);
    bit rd, wr, rsp;
    int old_pend;
    rd = rv & rr & ~rw;
    wr = rv & rr & rw;
    rsp = sv & sr;
    old_pend = m_pend;
    m_reads  = (clr ? perf_ctr_t'(0) : m_reads)  + perf_ctr_t'(rd);
    m_writes = (clr ? perf_ctr_t'(0) : m_writes) + perf_ctr_t'(wr);
    m_lat    = (clr ? perf_ctr_t'(0) : m_lat)    + perf_ctr_t'(old_pend);
    if (clr) m_err = 2'b00;
    if (rsp && !rd && old_pend == 0) m_err[0] = 1'b1;
    if (rd && !rsp && old_pend == MAX_PENDING) m_err[1] = 1'b1;
    if (rd && !rsp && old_pend < MAX_PENDING) m_pend = old_pend + 1;
    else if (rsp && !rd && old_pend > 0) m_pend = old_pend - 1;
    if (clr) m_peak = old_pend;
    else if (old_pend > m_peak) m_peak = old_pend;
  endtask

  task automatic check_all(input string pfx);
    check({pfx, "_reads"},   perf_mem_reads,   m_reads);
    check({pfx, "_writes"},  perf_mem_writes,  m_writes);
    check({pfx, "_latency"}, perf_mem_latency, m_lat);
    check({pfx, "_pending"}, pending_reads,    m_pend);
    check({pfx, "_err"},     perf_err,         m_err);
`ifdef PERF_MEM_PEAK_PENDING_EN
    check({pfx, "_peak"},    peak_pending,     m_peak);
`endif
  endtask

  task automatic check_zero(input string pfx);
    check({pfx, "_reads"},   perf_mem_reads,   0);
    check({pfx, "_writes"},  perf_mem_writes,  0);
    check({pfx, "_latency"}, perf_mem_latency, 0);
    check({pfx, "_pending"}, pending_reads,    0);
    check({pfx, "_err"},     perf_err,         0);
`ifdef PERF_MEM_PEAK_PENDING_EN
    check({pfx, "_peak"},    peak_pending,     0);
`endif
  endtask

  // driver: apply inputs for one cycle, advance model at the edge, check after
  task automatic cycle(input bit rv, rr, rw, sv, sr, clr);
    mem_req_valid = rv; mem_req_ready = rr; mem_req_rw = rw;
    mem_rsp_valid = sv; mem_rsp_ready = sr; perf_clear = clr;
    @(posedge clk);
    model_tick(rv, rr, rw, sv, sr, clr);
    #1;
    check_all("cyc");
  endtask

  task automatic idle_inputs();
    mem_req_valid = 0; mem_req_ready = 0; mem_req_rw = 0;
    mem_rsp_valid = 0; mem_rsp_ready = 0; perf_clear = 0;
  endtask

  // asynchronous reset, asserted away from the clock edge
  task automatic do_reset(input string tag);
    #2;
    idle_inputs();
    reset = 1'b1;
    #1;
    check_zero({tag, "_async"});
    model_zero();
    @(posedge clk);
    #1;
    check_zero({tag, "_held"});
    reset = 1'b0;
  endtask

  initial begin
    idle_inputs();
    model_zero();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero("por");
    reset = 1'b0;

    // single read, answered 5 cycles later
    cycle(1, 1, 0, 0, 0, 0);
    repeat (4) cycle(0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 1, 1, 0);
    check("lat5_reads", perf_mem_reads, 1);
    check("lat5_latency", perf_mem_latency, 5);
    check("lat5_pending", pending_reads, 0);
    check("lat5_err", perf_err, 0);
    do_reset("rst1");

    // overlapping reads, then a simultaneous read + response
    repeat (3) cycle(1, 1, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0);
    repeat (3) cycle(0, 0, 0, 1, 1, 0);
    check("ovl_reads", perf_mem_reads, 3);
    check("ovl_latency", perf_mem_latency, 12);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 1, 1, 0);
    check("same_cycle_pending", pending_reads, 1);
    cycle(0, 0, 0, 1, 1, 0);
    do_reset("rst2");

    // writes never touch pending; unaccepted requests count nothing
    repeat (10) cycle(1, 1, 1, 0, 0, 0);
    repeat (3) cycle(1, 0, 1, 0, 0, 0);
    repeat (3) cycle(1, 0, 0, 0, 0, 0);
    check("wr_writes", perf_mem_writes, 10);
    check("wr_reads", perf_mem_reads, 0);
    check("wr_latency", perf_mem_latency, 0);
    check("wr_pending", pending_reads, 0);

    // orphan response
    cycle(0, 0, 0, 1, 1, 0);
    check("unf_err", perf_err, 2'b01);
    check("unf_pending", pending_reads, 0);

    // clear in the same cycle as a read fire
    cycle(1, 1, 0, 0, 0, 1);
    check("clr_reads", perf_mem_reads, 1);
    check("clr_writes", perf_mem_writes, 0);
    check("clr_err", perf_err, 0);
    check("clr_pending", pending_reads, 1);
    do_reset("rst3");

    // one read beyond capacity
    repeat (65) cycle(1, 1, 0, 0, 0, 0);
    check("ovf_pending", pending_reads, 64);
    check("ovf_err", perf_err, 2'b10);
    check("ovf_reads", perf_mem_reads, 65);
    check("ovf_latency", perf_mem_latency, 2080);
    do_reset("rst4");

`ifdef PERF_MEM_PEAK_PENDING_EN
    repeat (7) cycle(1, 1, 0, 0, 0, 0);
    repeat (5) cycle(0, 0, 0, 1, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);
    check("peak_ramp", peak_pending, 7);
    check("peak_pend", pending_reads, 2);
    cycle(0, 0, 0, 0, 0, 1);
    check("peak_clear", peak_pending, 2);
    do_reset("rst5");
`endif

    // randomized traffic, with a reset mid-run while counters are nonzero
    for (int phase = 0; phase < 2; phase++) begin
      for (int i = 0; i < 1500; i++) begin
        cycle($urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 149) == 0);
      end
      if (phase == 0) do_reset("rst_mid");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
